countdown_timer: RTL and testbench

- 4-digit BCD countdown timer with 1/100 s resolution (00.00 to 99.99 s).
- Loaded from the slide switches, started and paused by a debounced button pulse, counts down to 00.00, then stops and raises an alarm.
- Sits beside the stopwatch on the board top level and drives the same hex-display decoders and LED bank.

---
 rtl/countdown_timer.sv | 190 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : 4-digit BCD countdown timer, 1/100 s resolution (00.00-99.99).
//             Loaded from a 16-bit BCD preset, started/paused by a pulse,
//             counts down to 00.00, then stops in DONE and raises the alarm.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous active-high reset
//             load       - 1-cycle pulse: load preset (digits > 9 saturate)
//             start_stop - 1-cycle pulse: toggle run/pause
//             preset     - BCD preset {d3,d2,d1,d0}, d0 = 1/100 s
//             dout0..3   - current BCD digits, dout0 least significant
//             running    - high while counting
//             done       - sticky, high after reaching 00.00
//             alarm      - alarm LED drive
//  Options  : COUNTDOWN_ALARM_BLINK_EN - when defined, alarm blinks in DONE
//             with a half-period of ALARM_TICKS ticks; otherwise alarm = done.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
   parameter int CLK_HZ      = 50000000,
   parameter int TICK_HZ     = 100,
   parameter int ALARM_TICKS = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        start_stop,
   input  logic [15:0] preset,
   output logic [3:0]  dout0,
   output logic [3:0]  dout1,
   output logic [3:0]  dout2,
   output logic [3:0]  dout3,
   output logic        running,
   output logic        done,
   output logic        alarm
);

   localparam int            C_DIV       = CLK_HZ / TICK_HZ;
   localparam int            C_PW        = $clog2(C_DIV);
   localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(C_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0][3:0]   r_digits;
   logic [3:0][3:0]   w_digits_nxt;
   logic [3:0][3:0]   w_dec;
   logic [3:0][3:0]   w_preset_sat;
   logic              w_borrow;
   logic [C_PW-1:0]   r_presc;
   logic              w_presc_en;
   logic              w_presc_clr;
   logic              w_tick;

   // ---------------------------------------------------------------- prescaler
`ifdef COUNTDOWN_ALARM_BLINK_EN
   // The prescaler keeps running in DONE to pace the alarm blink.
   assign w_presc_en = (r_state == S_RUN) || (r_state == S_DONE);
`else
   assign w_presc_en = (r_state == S_RUN);
`endif

   assign w_tick      = w_presc_en && (r_presc == C_PRESC_MAX);
   // Clearing on every state change makes the first decrement after a resume
   // land exactly DIV clocks later.
   assign w_presc_clr = load || (w_state_nxt != r_state);

   always_ff @(posedge clk) begin
      if (reset || w_presc_clr) begin
         r_presc <= '0;
      end else if (w_presc_en) begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
   end

   // --------------------------------------------------------- BCD helpers
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_preset_sat[i] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
      end
   end

   // Ripple-borrow BCD decrement; only used while digits are non-zero.
   always_comb begin
      w_dec    = r_digits;
      w_borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (w_borrow) begin
            if (r_digits[i] == 4'd0) begin
               w_dec[i] = 4'd9;
            end else begin
               w_dec[i] = r_digits[i] - 4'd1;
               w_borrow = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_digits <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_digits <= w_digits_nxt;
      end
   end

   // Priority: load > start_stop > tick.
   always_comb begin
      w_state_nxt  = r_state;
      w_digits_nxt = r_digits;
      if (load) begin
         w_state_nxt  = S_IDLE;
         w_digits_nxt = w_preset_sat;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_stop && (r_digits != '0)) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (start_stop) begin
                  w_state_nxt = S_IDLE;
               end else if (w_tick) begin
                  w_digits_nxt = w_dec;
                  if (w_dec == '0) begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- alarm
`ifdef COUNTDOWN_ALARM_BLINK_EN
   localparam int C_AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
   localparam logic [C_AW-1:0] C_ALARM_MAX = C_AW'(ALARM_TICKS - 1);

   logic [C_AW-1:0] r_blink_cnt;
   logic            r_alarm;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         r_blink_cnt <= '0;
         r_alarm     <= 1'b0;
      end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
         // Blink starts high on entry to DONE.
         r_blink_cnt <= '0;
         r_alarm     <= 1'b1;
      end else if ((r_state == S_DONE) && w_tick) begin
         if (r_blink_cnt == C_ALARM_MAX) begin
            r_blink_cnt <= '0;
            r_alarm     <= ~r_alarm;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign alarm = r_alarm;
`else
   assign alarm = (r_state == S_DONE);
`endif

   // -------------------------------------------------------------- outputs
   assign dout0   = r_digits[0];
   assign dout1   = r_digits[1];
   assign dout2   = r_digits[2];
   assign dout3   = r_digits[3];
   assign running = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_timer
//  Purpose  : Directed self-checking bench for countdown_timer with
//             CLK_HZ=1000, TICK_HZ=100 (DIV=10), ALARM_TICKS=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

   logic        clk;
   logic        reset;
   logic        load;
   logic        start_stop;
   logic [15:0] preset;
   logic [3:0]  dout0, dout1, dout2, dout3;
   logic        running, done, alarm;

   int total = 0;
   int bad   = 0;

   countdown_timer #(
      .CLK_HZ      (1000),
      .TICK_HZ     (100),
      .ALARM_TICKS (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .start_stop (start_stop),
      .preset     (preset),
      .dout0      (dout0),
      .dout1      (dout1),
      .dout2      (dout2),
      .dout3      (dout3),
      .running    (running),
      .done       (done),
      .alarm      (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [15:0] w_digits = {dout3, dout2, dout1, dout0};

   // Inputs change just after a falling edge; outputs are sampled on falling
   // edges, half a period after the rising edge that updated them.
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Digits plus {running, done, alarm} in one comparison.
   task automatic check_all(input string tag, input logic [15:0] d, input logic r,
                            input logic dn, input logic a);
      check({tag, "_digits"},  w_digits,        d);
      check({tag, "_flags"},   {13'd0, running, done, alarm}, {13'd0, r, dn, a});
   endtask

   task automatic pulse_load(input logic [15:0] p);
      preset = p;
      load   = 1'b1;
      cyc(1);
      load   = 1'b0;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      load       = 1'b0;
      start_stop = 1'b0;
      preset     = 16'h0000;
      cyc(2);
      check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Basic countdown from 00.03
      pulse_load(16'h0003);
      check_all("load3", 16'h0003, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      check_all("start", 16'h0003, 1'b1, 1'b0, 1'b0);
      cyc(9);
      check_all("pre_tick1", 16'h0003, 1'b1, 1'b0, 1'b0);
      cyc(1);
      check_all("tick1", 16'h0002, 1'b1, 1'b0, 1'b0);
      cyc(10);
      check_all("tick2", 16'h0001, 1'b1, 1'b0, 1'b0);
      cyc(10);
      check_all("zero", 16'h0000, 1'b0, 1'b1, 1'b1);

      // Alarm in DONE: blinks every 20 clocks with the feature, steady otherwise
      cyc(19);
      check_all("alarm_hold", 16'h0000, 1'b0, 1'b1, 1'b1);
      cyc(1);
`ifdef COUNTDOWN_ALARM_BLINK_EN
      check_all("alarm_blink", 16'h0000, 1'b0, 1'b1, 1'b0);
      cyc(20);
      check_all("alarm_blink2", 16'h0000, 1'b0, 1'b1, 1'b1);
`else
      check_all("alarm_steady", 16'h0000, 1'b0, 1'b1, 1'b1);
      cyc(20);
      check_all("alarm_steady2", 16'h0000, 1'b0, 1'b1, 1'b1);
`endif

      // start_stop in DONE is ignored
      pulse_ss();
      cyc(1);
      check("done_ss_done", {15'd0, done}, 16'd1);
      check("done_ss_run",  {15'd0, running}, 16'd0);

      // Borrow through three digits; load clears done/alarm
      pulse_load(16'h1000);
      check_all("load1000", 16'h1000, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      cyc(10);
      check_all("borrow999", 16'h0999, 1'b1, 1'b0, 1'b0);

      // Pause on a tick edge discards that decrement
      cyc(9);
      pulse_ss();
      check_all("pause_on_tick", 16'h0999, 1'b0, 1'b0, 1'b0);
      cyc(15);
      check_all("paused_hold", 16'h0999, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      check_all("resume", 16'h0999, 1'b1, 1'b0, 1'b0);
      cyc(9);
      check_all("resume_pre", 16'h0999, 1'b1, 1'b0, 1'b0);
      cyc(1);
      check_all("resume_tick", 16'h0998, 1'b1, 1'b0, 1'b0);

      // Load while running stops and reloads
      pulse_load(16'h0100);
      check_all("load_in_run", 16'h0100, 1'b0, 1'b0, 1'b0);
      pulse_ss();
      cyc(10);
      check_all("borrow099", 16'h0099, 1'b1, 1'b0, 1'b0);

      // load and start_stop together: load wins (from IDLE)
      pulse_ss();
      check_all("pause2", 16'h0099, 1'b0, 1'b0, 1'b0);
      preset     = 16'h0005;
      load       = 1'b1;
      start_stop = 1'b1;
      cyc(1);
      load       = 1'b0;
      start_stop = 1'b0;
      check_all("load_and_ss", 16'h0005, 1'b0, 1'b0, 1'b0);

      // start_stop with 0000 is ignored
      pulse_load(16'h0000);
      pulse_ss();
      cyc(12);
      check_all("ss_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0);

      // Saturation of out-of-range preset digits
      pulse_load(16'hFFFF);
      check_all("sat_ffff", 16'h9999, 1'b0, 1'b0, 1'b0);
      pulse_load(16'h1A3F);
      check_all("sat_1a3f", 16'h1939, 1'b0, 1'b0, 1'b0);

      // Saturated value counts correctly, then reset mid-run
      pulse_ss();
      cyc(10);
      check_all("run1939", 16'h1938, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check_all("reset_run", 16'h0000, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
